// File: rtl/key_pkg.sv
// key_pkg
//   Shared definitions for the key provider: FSM state encoding and the
//   default key width, decoy key and failure limit.
//   No ports; imported by key_provider and key_deser.
package key_pkg;

    localparam int                       KEY_W_DEF     = 3;
    localparam logic [KEY_W_DEF-1:0]     DECOY_KEY_DEF = 3'b000;
    localparam int                       MAX_FAIL_DEF  = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CHECK   = 3'd2,
        HOLD    = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

endpackage

// File: rtl/key_deser.sv
// key_deser
//   Deserialises one key frame: KEY_W data bits (LSB first) followed by one
//   even-parity bit. Keeps a running parity so the check is ready as soon as
//   the last beat lands.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : restart the frame (bit count, parity, shift register)
//   beat        : accept bit_in this cycle
//   bit_in      : serial bit
//   frame_done  : the current beat is the parity beat
//   data        : deserialised data bits, data[0] = first bit received
//   parity_ok   : even parity holds over data + parity bit
module key_deser
    import key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             beat,
    input  logic             bit_in,
    output logic             frame_done,
    output logic [KEY_W-1:0] data,
    output logic             parity_ok
);

    localparam int               CNT_W = $clog2(KEY_W + 2);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(KEY_W);

    logic [KEY_W:0]   shift;
    logic [CNT_W-1:0] cnt;
    logic             parity;

    // Bits enter at the top and move down, so after KEY_W+1 beats the first
    // bit sits at shift[0] and the parity bit at shift[KEY_W].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift  <= '0;
            cnt    <= '0;
            parity <= 1'b0;
        end else if (clear) begin
            shift  <= '0;
            cnt    <= '0;
            parity <= 1'b0;
        end else if (beat) begin
            shift  <= {bit_in, shift[KEY_W:1]};
            cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
            parity <= parity ^ bit_in;
        end
    end

    assign frame_done = beat && (cnt == LAST);
    assign data       = shift[KEY_W-1:0];
    assign parity_ok  = ~parity;

endmodule

// File: rtl/key_provider.sv
// key_provider
//   Drives the unlock key onto a logic-locked core. Loads a framed serial key
//   from NVM, parity-checks it and holds it; drives a decoy key until a good
//   frame lands, and locks out permanently after MAX_FAIL bad frames.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   load_req   : start or restart a key load
//   ser_valid  : serial bit valid
//   ser_data   : serial key bit
//   ser_ready  : a bit is accepted this cycle when ser_valid & ser_ready
//   key        : key bus to the locked core (registered)
//   key_valid  : key holds the loaded frame (registered)
//   key_err    : last frame failed parity, sticky until next load (registered)
//   tamper     : failure limit reached, sticky until reset (registered)
module key_provider
    import key_pkg::*;
#(
    parameter int               KEY_W     = KEY_W_DEF,
    parameter logic [KEY_W-1:0] DECOY_KEY = DECOY_KEY_DEF,
    parameter int               MAX_FAIL  = MAX_FAIL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_req,
    input  logic             ser_valid,
    input  logic             ser_data,
    output logic             ser_ready,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_err,
    output logic             tamper
);

    localparam int                FAIL_W = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);

    state_t            state;
    logic [FAIL_W-1:0] fail_cnt;
    logic [FAIL_W-1:0] fail_next;
    logic              load_go;
    logic              beat;
    logic              frame_done;
    logic              parity_ok;
    logic [KEY_W-1:0]  frame_data;

    // A load only starts from states that can take one; once tampered it is
    // dropped entirely.
    assign load_go = load_req && !tamper &&
                     (state == IDLE || state == SHIFT || state == HOLD);

    // The load_req cycle itself never accepts a beat.
    assign ser_ready = (state == SHIFT) && !load_req;
    assign beat      = ser_valid && ser_ready;
    assign fail_next = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + 1'b1;

    key_deser #(
        .KEY_W (KEY_W)
    ) u_deser (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (load_go),
        .beat       (beat),
        .bit_in     (ser_data),
        .frame_done (frame_done),
        .data       (frame_data),
        .parity_ok  (parity_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fail_cnt  <= '0;
            key       <= DECOY_KEY;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
            tamper    <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (load_go) begin
                        state     <= SHIFT;
                        key       <= DECOY_KEY;
                        key_valid <= 1'b0;
                        key_err   <= 1'b0;
                    end
                end
                SHIFT: begin
                    // A restart aborts the frame without counting a failure.
                    if (load_go) begin
                        key_err <= 1'b0;
                    end else if (frame_done) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (parity_ok) begin
                        key       <= frame_data;
                        key_valid <= 1'b1;
                        fail_cnt  <= '0;
                        state     <= HOLD;
                    end else begin
                        key_err  <= 1'b1;
                        fail_cnt <= fail_next;
                        if (fail_next == FAIL_LIMIT) begin
                            tamper <= 1'b1;
                            state  <= LOCKOUT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                LOCKOUT: begin
                    key       <= DECOY_KEY;
                    key_valid <= 1'b0;
                end
                default: begin
                    state     <= LOCKOUT;
                    key       <= DECOY_KEY;
                    key_valid <= 1'b0;
                    tamper    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_provider.sv
// tb_key_provider
//   Scoreboard bench for key_provider: frame results are queued as they are
//   sent and checked by a monitor when key_valid or key_err rises.
module tb_key_provider;

    localparam int KW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_req;
    logic          ser_valid;
    logic          ser_data;
    logic          ser_ready;
    logic [KW-1:0] key;
    logic          key_valid;
    logic          key_err;
    logic          tamper;

    key_provider #(
        .KEY_W     (KW),
        .DECOY_KEY (3'b000),
        .MAX_FAIL  (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_req  (load_req),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready),
        .key       (key),
        .key_valid (key_valid),
        .key_err   (key_err),
        .tamper    (tamper)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [KW-1:0] key;
        logic          kv;
        logic          ke;
        logic          tp;
        int            at;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: a frame result is presented when key_valid or key_err rises.
    logic prev_kv = 1'b0;
    logic prev_ke = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if ((key_valid && !prev_kv) || (key_err && !prev_ke)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_result actual=key%0h/kv%0b/ke%0b required=none",
                         key, key_valid, key_err);
            end else begin
                e = sb.pop_front();
                check_output("ev_key",    32'(key),       32'(e.key));
                check_output("ev_kvalid", 32'(key_valid), 32'(e.kv));
                check_output("ev_kerr",   32'(key_err),   32'(e.ke));
                check_output("ev_tamper", 32'(tamper),    32'(e.tp));
                check_output("ev_cycle",  32'(cyc),       32'(e.at));
            end
        end
        prev_kv = key_valid;
        prev_ke = key_err;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap, input logic rdy);
        ser_valid = 1'b0;
        ser_data  = ~b;
        repeat (gap) tick();
        ser_valid = 1'b1;
        ser_data  = b;
        #1;
        check_output("ser_ready_beat", 32'(ser_ready), 32'(rdy));
        tick();
        ser_valid = 1'b0;
    endtask

    // bits[0] is sent first; gaps holds a 2-bit idle count per bit.
    task automatic apply_stimulus(input logic [3:0] bits, input logic [7:0] gaps, input logic rdy);
        for (int i = 0; i < 4; i++) begin
            send_bit(bits[i], int'(gaps[2*i +: 2]), rdy);
        end
    endtask

    // Result appears one cycle after the parity-beat edge just passed.
    task automatic push_expect(input logic [KW-1:0] k, input logic kv, input logic ke, input logic tp);
        sb.push_back('{key: k, kv: kv, ke: ke, tp: tp, at: cyc + 1});
    endtask

    task automatic finish_frame();
        repeat (3) tick();
        check_output("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_key",    32'(key),       32'd0);
        check_output("rst_kvalid", 32'(key_valid), 32'd0);
        check_output("rst_kerr",   32'(key_err),   32'd0);
        check_output("rst_tamper", 32'(tamper),    32'd0);
        check_output("rst_ready",  32'(ser_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        load_req  = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        repeat (3) tick();
        check_output("reset_key",    32'(key),       32'd0);
        check_output("reset_kvalid", 32'(key_valid), 32'd0);
        check_output("reset_kerr",   32'(key_err),   32'd0);
        check_output("reset_tamper", 32'(tamper),    32'd0);
        check_output("reset_ready",  32'(ser_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: good frame 1,0,1,p=0
        $display("[TB] test 1: good frame");
        pulse_load();
        apply_stimulus(4'b0101, 8'h00, 1'b1);
        push_expect(3'b101, 1'b1, 1'b0, 1'b0);
        finish_frame();
        check_output("t1_ready_hold", 32'(ser_ready), 32'd0);
        check_output("t1_key_hold",   32'(key),       32'h5);

        // 2: bad parity, then a good frame clears the fail count
        $display("[TB] test 2: bad parity then recovery");
        pulse_load();
        apply_stimulus(4'b1101, 8'h00, 1'b1);
        push_expect(3'b000, 1'b0, 1'b1, 1'b0);
        finish_frame();
        pulse_load();
        check_output("t2_kerr_cleared", 32'(key_err), 32'd0);
        apply_stimulus(4'b0101, 8'h00, 1'b1);
        push_expect(3'b101, 1'b1, 1'b0, 1'b0);
        finish_frame();

        // 3: three bad frames in a row reach tamper
        $display("[TB] test 3: tamper lockout");
        for (int n = 1; n <= 3; n++) begin
            pulse_load();
            apply_stimulus(4'b1101, 8'h00, 1'b1);
            push_expect(3'b000, 1'b0, 1'b1, (n == 3));
            finish_frame();
        end
        pulse_load();
        apply_stimulus(4'b0101, 8'h00, 1'b0);
        repeat (3) tick();
        check_output("t3_lock_key",    32'(key),       32'd0);
        check_output("t3_lock_kvalid", 32'(key_valid), 32'd0);
        check_output("t3_lock_tamper", 32'(tamper),    32'd1);
        check_output("t3_lock_kerr",   32'(key_err),   32'd1);
        async_reset_check();

        // 4: restart after two beats; the load_req-cycle bit must be dropped
        $display("[TB] test 4: restart mid-frame");
        pulse_load();
        send_bit(1'b1, 0, 1'b1);
        send_bit(1'b1, 0, 1'b1);
        load_req  = 1'b1;
        ser_valid = 1'b1;
        ser_data  = 1'b1;
        #1;
        check_output("t4_ready_on_load", 32'(ser_ready), 32'd0);
        tick();
        load_req  = 1'b0;
        ser_valid = 1'b0;
        apply_stimulus(4'b0110, 8'h00, 1'b1);
        push_expect(3'b110, 1'b1, 1'b0, 1'b0);
        finish_frame();
        check_output("t4_kerr", 32'(key_err), 32'd0);

        // 5: gaps between beats, then a reset mid-frame, then gap-free
        $display("[TB] test 5: valid gaps and async reset");
        pulse_load();
        apply_stimulus(4'b0011, 8'b01_11_00_10, 1'b1);
        push_expect(3'b011, 1'b1, 1'b0, 1'b0);
        finish_frame();
        pulse_load();
        send_bit(1'b1, 0, 1'b1);
        send_bit(1'b0, 1, 1'b1);
        async_reset_check();
        pulse_load();
        apply_stimulus(4'b0011, 8'h00, 1'b1);
        push_expect(3'b011, 1'b1, 1'b0, 1'b0);
        finish_frame();

        // 6: HOLD ignores serial traffic; load_req drops the key
        $display("[TB] test 6: hold stability");
        for (int i = 0; i < 6; i++) begin
            ser_valid = i[0];
            ser_data  = ~i[1];
            tick();
            check_output("t6_key_stable", 32'(key),       32'h3);
            check_output("t6_kv_stable",  32'(key_valid), 32'd1);
            check_output("t6_ready_low",  32'(ser_ready), 32'd0);
        end
        ser_valid = 1'b0;
        pulse_load();
        #1;
        check_output("t6_kv_drop",  32'(key_valid), 32'd0);
        check_output("t6_key_decoy", 32'(key),      32'd0);
        check_output("t6_ready_up", 32'(ser_ready), 32'd1);

        repeat (2) tick();
        check_output("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
